// File: rtl/ram_bus_master.sv
// Single-port RAM bus master: turns valid/ready word commands into timed RAM cycles on a shared tristate bus.
// Optional power-up zero fill of all 32 words is enabled by defining RAM_BUS_MASTER_CLEAR_EN.
module ram_bus_master (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [4:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic        ram_ena,
    output logic        ram_wena,
    output logic [4:0]  ram_addr,
    inout  wire  [31:0] ram_data
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_CAPTURE
`ifdef RAM_BUS_MASTER_CLEAR_EN
        , ST_CLEAR
`endif
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_init_armed;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_busy;
    logic        r_ram_ena;
    logic        r_ram_wena;
    logic [4:0]  r_ram_addr;
    logic        r_drive;
    logic [31:0] r_dout;

    logic        w_ram_ena_next;
    logic        w_ram_wena_next;
    logic [4:0]  w_ram_addr_next;
    logic        w_drive_next;
    logic [31:0] w_dout_next;

`ifdef RAM_BUS_MASTER_CLEAR_EN
    logic [4:0]  r_clr_cnt;
    logic [4:0]  w_clr_cnt_next;
`endif

    // Next state plus the registered-output values that state will present.
    always_comb begin
        w_state_next    = r_state;
        w_ram_addr_next = r_ram_addr;
        w_dout_next     = r_dout;
`ifdef RAM_BUS_MASTER_CLEAR_EN
        w_clr_cnt_next  = r_clr_cnt;
`endif
        case (r_state)
            ST_INIT: begin
                if (r_init_armed) begin
`ifdef RAM_BUS_MASTER_CLEAR_EN
                    w_state_next   = ST_CLEAR;
                    w_clr_cnt_next = 5'd0;
`else
                    w_state_next   = ST_IDLE;
`endif
                end
            end
            ST_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_state_next    = req_wr ? ST_WRITE : ST_READ;
                    w_ram_addr_next = req_addr;
                    w_dout_next     = req_wdata;
                end
            end
            ST_WRITE:   w_state_next = ST_IDLE;
            ST_READ:    w_state_next = ST_CAPTURE;
            ST_CAPTURE: w_state_next = ST_IDLE;
`ifdef RAM_BUS_MASTER_CLEAR_EN
            ST_CLEAR: begin
                if (r_clr_cnt == 5'd31) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_clr_cnt_next = r_clr_cnt + 5'd1;
                end
            end
`endif
            default:    w_state_next = ST_INIT;
        endcase

        w_ram_ena_next  = (w_state_next == ST_WRITE) || (w_state_next == ST_READ);
        w_ram_wena_next = (w_state_next == ST_WRITE);
`ifdef RAM_BUS_MASTER_CLEAR_EN
        if (w_state_next == ST_CLEAR) begin
            w_ram_ena_next  = 1'b1;
            w_ram_wena_next = 1'b1;
            w_ram_addr_next = w_clr_cnt_next;
            w_dout_next     = 32'd0;
        end
`endif
        // The bus is only ever driven in cycles that write.
        w_drive_next = w_ram_wena_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_INIT;
            r_init_armed <= 1'b0;
            r_req_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= 32'd0;
            r_busy       <= 1'b1;
            r_ram_ena    <= 1'b0;
            r_ram_wena   <= 1'b0;
            r_ram_addr   <= 5'd0;
            r_drive      <= 1'b0;
            r_dout       <= 32'd0;
`ifdef RAM_BUS_MASTER_CLEAR_EN
            r_clr_cnt    <= 5'd0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_init_armed <= (r_state == ST_INIT);
            r_req_ready  <= (w_state_next == ST_IDLE);
            r_busy       <= (w_state_next != ST_IDLE);
            r_rsp_valid  <= (r_state == ST_CAPTURE);
            if (r_state == ST_CAPTURE) begin
                r_rsp_rdata <= ram_data;
            end
            r_ram_ena    <= w_ram_ena_next;
            r_ram_wena   <= w_ram_wena_next;
            r_ram_addr   <= w_ram_addr_next;
            r_drive      <= w_drive_next;
            r_dout       <= w_dout_next;
`ifdef RAM_BUS_MASTER_CLEAR_EN
            r_clr_cnt    <= w_clr_cnt_next;
`endif
        end
    end

    assign ram_data  = r_drive ? r_dout : 32'hzzzz_zzzz;
    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign busy      = r_busy;
    assign ram_ena   = r_ram_ena;
    assign ram_wena  = r_ram_wena;
    assign ram_addr  = r_ram_addr;

endmodule

// File: tb/tb_ram_bus_master.sv
// Self-checking bench for ram_bus_master: synchronous-read RAM model on the shared bus,
// array reference model of memory contents, directed sequences then random traffic.
module tb_ram_bus_master;

`ifdef RAM_BUS_MASTER_CLEAR_EN
    localparam int RDY = 34;
`else
    localparam int RDY = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic        ram_ena;
    logic        ram_wena;
    logic [4:0]  ram_addr;
    wire  [31:0] ram_data;

    int n_checks = 0;
    int n_fail   = 0;

    ram_bus_master dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .ram_ena   (ram_ena),
        .ram_wena  (ram_wena),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data registered, driven onto the bus for one cycle after a read-enable cycle.
    logic [31:0] ram_mem [32];
    logic [31:0] ram_q     = 32'd0;
    logic        ram_oe    = 1'b0;
    logic        mem_ready = 1'b0;
    int          hits3     = 0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 32; i++) ram_mem[i] <= 32'hC0DE_0000 | i;
            mem_ready <= 1'b1;
        end else if (ram_ena && ram_wena) begin
            ram_mem[ram_addr] <= ram_data;
        end
        if (ram_ena && ram_wena && ram_addr == 5'd3 && ram_data == 32'hA5A5_A5A5) hits3 <= hits3 + 1;
        ram_oe <= ram_ena && !ram_wena;
        if (ram_ena && !ram_wena) ram_q <= ram_mem[ram_addr];
    end

    assign ram_data = ram_oe ? ram_q : 32'hzzzz_zzzz;

    logic [31:0] ref_mem [32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"},  32'(req_ready), 32'd0);
        check({tag, "_rspv"},   32'(rsp_valid), 32'd0);
        check({tag, "_rdata"},  rsp_rdata,      32'd0);
        check({tag, "_busy"},   32'(busy),      32'd1);
        check({tag, "_ena"},    32'(ram_ena),   32'd0);
        check({tag, "_wena"},   32'(ram_wena),  32'd0);
        check({tag, "_addr"},   32'(ram_addr),  32'd0);
    endtask

    // Called on the negedge just after reset release; samples cycles 1..RDY.
    task automatic startup();
        for (int c = 1; c <= RDY; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("init_ena",  32'(ram_ena),  32'd0);
                check("init_wena", 32'(ram_wena), 32'd0);
            end
            check($sformatf("ready_cycle%0d", c), 32'(req_ready), 32'(c == RDY));
        end
`ifdef RAM_BUS_MASTER_CLEAR_EN
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
`endif
    endtask

    // Starts at a negedge; returns at the negedge of the IDLE cycle that follows the command.
    task automatic send(input bit wr, input logic [4:0] a, input logic [31:0] d);
        int w;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        w = 0;
        while (!req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("accept_timeout", 32'(req_ready), 32'd1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check($sformatf("c1_ena_a%0d", a),  32'(ram_ena),  32'd1);
        check($sformatf("c1_wena_a%0d", a), 32'(ram_wena), 32'(wr));
        check($sformatf("c1_addr_a%0d", a), 32'(ram_addr), 32'(a));
        check("c1_busy", 32'(busy), 32'd1);
        if (wr) begin
            check($sformatf("wr_bus_a%0d", a), ram_data, d);
            ref_mem[a] = d;
            @(negedge clk);
            check("wr_idle_ready", 32'(req_ready), 32'd1);
            check("wr_idle_ena",   32'(ram_ena),   32'd0);
            check("wr_idle_busy",  32'(busy),      32'd0);
            check("wr_idle_addr",  32'(ram_addr),  32'(a));
        end else begin
            check("rd_c1_rspv", 32'(rsp_valid), 32'd0);
            @(negedge clk);
            check("rd_cap_ena",  32'(ram_ena),   32'd0);
            check("rd_cap_rspv", 32'(rsp_valid), 32'd0);
            check($sformatf("rd_cap_bus_a%0d", a), ram_data, ref_mem[a]);
            @(negedge clk);
            check("rd_c3_rspv", 32'(rsp_valid), 32'd1);
            check($sformatf("rd_data_a%0d", a), rsp_rdata, ref_mem[a]);
            check("rd_c3_ready", 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'hC0DE_0000 | i;
        rst_n = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = 5'd0; req_wdata = 32'd0;
        #2 rst_n = 1'b0;
        #1 check_reset_vals("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        startup();

        // Write then read back with exact latency.
        send(1'b1, 5'd5, 32'hDEAD_BEEF);
        send(1'b0, 5'd5, 32'd0);
        @(negedge clk);
        check("rspv_pulse_end", 32'(rsp_valid), 32'd0);
        check("rdata_held", rsp_rdata, 32'hDEAD_BEEF);

        // Read 31, immediately write 31, read again.
        send(1'b0, 5'd31, 32'd0);
        send(1'b1, 5'd31, 32'h1234_5678);
        send(1'b0, 5'd31, 32'd0);

        // Command held through reset and start-up.
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 5'd3; req_wdata = 32'hA5A5_A5A5;
        #1 check_reset_vals("rst2");
        h0 = hits3;
        @(negedge clk);
        rst_n = 1'b1;
        startup();
        send(1'b1, 5'd3, 32'hA5A5_A5A5);
        repeat (3) @(negedge clk);
        check("held_write_once", 32'(hits3 - h0), 32'd1);
        send(1'b0, 5'd3, 32'd0);

        // Reset pulsed during a read of address 7.
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 5'd7;
        @(posedge clk);
        #2 rst_n = 1'b0;
        req_valid = 1'b0;
        #1 check_reset_vals("midrd");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("midrd_no_rspv", 32'(rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        startup();
        send(1'b0, 5'd7, 32'd0);
        send(1'b0, 5'd0, 32'd0);
        send(1'b0, 5'd16, 32'd0);
        send(1'b0, 5'd31, 32'd0);

        // Random traffic against the reference memory.
        for (int k = 0; k < 40; k++) begin
            send(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_bus_master.md
RAM_BUS_MASTER -- requirements
Module: ram_bus_master

Interface
REQ-001 The block SHALL have the port `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port `req_valid`, input, 1 bit: the requester presents a command.
REQ-004 The block SHALL have the port `req_ready`, output, 1 bit: the block accepts a command this cycle.
REQ-005 The block SHALL have the port `req_wr`, input, 1 bit: 1 = write, 0 = read.
REQ-006 The block SHALL have the port `req_addr`, input, 5 bits: word address, 0..31.
REQ-007 The block SHALL have the port `req_wdata`, input, 32 bits: write data.
REQ-008 The block SHALL have the port `rsp_valid`, output, 1 bit: a one-cycle read-response pulse.
REQ-009 The block SHALL have the port `rsp_rdata`, output, 32 bits: read data, valid while `rsp_valid`=1 and held afterwards.
REQ-010 The block SHALL have the port `busy`, output, 1 bit: 1 whenever the FSM is not in IDLE.
REQ-011 The block SHALL have the port `ram_ena`, output, 1 bit: RAM enable.
REQ-012 The block SHALL have the port `ram_wena`, output, 1 bit: RAM write enable.
REQ-013 The block SHALL have the port `ram_addr`, output, 5 bits: RAM address.
REQ-014 The block SHALL have the port `ram_data`, inout, 32 bits: the shared bidirectional RAM data bus.

Function
REQ-015 The FSM SHALL have the states INIT, IDLE, WRITE, READ, CAPTURE and, when enabled, CLEAR; all outputs SHALL be registered.
REQ-016 A transfer SHALL occur on a rising edge with `req_valid`=1 and `req_ready`=1; `req_ready` SHALL be 1 only in IDLE.
REQ-017 The requester SHALL hold `req_wr`, `req_addr` and `req_wdata` stable while `req_valid`=1 and `req_ready`=0; the block SHALL latch them at transfer.
REQ-018 INIT SHALL last exactly 1 cycle with `ram_ena`=0, so the RAM output register is forced to Z before any drive; without CLEAR, INIT SHALL go to IDLE.
REQ-019 An accepted write SHALL go to WRITE for exactly 1 cycle, then to IDLE.
REQ-020 In WRITE: `ram_ena`=1, `ram_wena`=1, `ram_addr` = latched address, and `ram_data` driven with the latched data.
REQ-021 An accepted read SHALL go to READ for 1 cycle: `ram_ena`=1, `ram_wena`=0, `ram_data` = Z.
REQ-022 READ SHALL be followed by CAPTURE for 1 cycle: `ram_ena`=0, `ram_data` = Z, and `ram_data` sampled into `rsp_rdata` at the end of the cycle.
REQ-023 After CAPTURE, `rsp_valid` SHALL pulse high for 1 cycle in the following IDLE cycle.
REQ-024 Read latency SHALL be exactly 3 cycles from the accepting edge to `rsp_valid`=1.
REQ-025 Write occupancy SHALL be 2 cycles per command (WRITE, IDLE); read occupancy SHALL be 3 cycles per command (READ, CAPTURE, IDLE).
REQ-026 The block SHALL drive `ram_data` only in WRITE or CLEAR and SHALL release it to Z in every other state.
REQ-027 In all other states `ram_ena`=0 and `ram_wena`=0, so there is never bus contention, including a write that immediately follows a read.
REQ-028 `ram_addr` SHALL hold its last value when idle.
REQ-029 Address 31 SHALL need no special handling; there is no wrap or carry logic on the request path.
REQ-030 `req_valid` during INIT or CLEAR SHALL be stalled (`req_ready`=0), not dropped.

Reset
REQ-031 Asserting `rst_n`=0 SHALL immediately set `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `busy`=1, `ram_ena`=0, `ram_wena`=0, `ram_addr`=0, `ram_data`=Z, and state = INIT, clear counter = 0.
REQ-032 Reset mid-operation SHALL abandon the command in flight with no `rsp_valid` and no further RAM write; RAM contents already written are undefined-by-spec.
REQ-033 After `rst_n` rises, the first rising edge SHALL start INIT.

Configuration
REQ-034 With the macro `RAM_BUS_MASTER_CLEAR_EN` defined, INIT SHALL go to CLEAR.
REQ-035 CLEAR SHALL write 0 to addresses 0..31, one per cycle, with a 5-bit counter (32 cycles, `ram_ena`=`ram_wena`=1), then go to IDLE; `req_ready` SHALL first be 1 on cycle 34 after reset release.
REQ-036 With `RAM_BUS_MASTER_CLEAR_EN` undefined, the CLEAR state and counter SHALL not exist, and `req_ready` SHALL first be 1 on cycle 2 after reset release.

Verification
REQ-037 Reset release, no requests -> `ram_ena`=0 in cycle 1, `req_ready`=1 from cycle 2 (cycle 34 with CLEAR), `ram_data` never driven by the block in INIT or IDLE.
REQ-038 Write addr 5 = 0xDEADBEEF, then read addr 5 -> `rsp_valid` exactly 3 cycles after the read is accepted, `rsp_rdata`=0xDEADBEEF.
REQ-039 Read addr 31 immediately followed by write addr 31 = 0x12345678, then read -> no X on `ram_data` in any cycle, second `rsp_rdata`=0x12345678.
REQ-040 `req_valid` held during INIT/CLEAR with addr 3 = 0xA5A5A5A5 -> accepted on the first IDLE cycle, written exactly once.
REQ-041 `rst_n` pulsed low during READ of addr 7 -> no `rsp_valid`, outputs at reset values within the same cycle, normal operation after restart.
REQ-042 With CLEAR enabled, read addresses 0, 16, 31 after CLEAR -> `rsp_rdata`=0 for each.
